// File: rtl/bomb_placer.sv
// Board generator for the 8x8 minesweeper core: LFSR bomb placement followed by a
// 64-cycle neighbour count sweep. Optional macro BOMB_PLACER_SAFE_START_EN keeps safe_cell bomb-free.
module bomb_placer #(
  parameter logic [15:0] LFSR_SEED   = 16'hACE1,
  parameter int unsigned RETRY_LIMIT = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [5:0]   bomb_count,
  input  logic [5:0]   safe_cell,
  output logic [63:0]  bomb_map,
  output logic [255:0] adj_count,
  output logic         busy,
  output logic         done
);

  localparam int unsigned RETRY_W = $clog2(RETRY_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, PLACE, COUNT, DONE} state_t;

  state_t               state, state_next;
  logic [15:0]          lfsr;
  logic [5:0]           target;
  logic [5:0]           placed;
  logic [RETRY_W-1:0]   retry;
  logic [5:0]           probe_ptr;
  logic [5:0]           ptr;
  logic                 probe_mode;
  logic [5:0]           cand;
  logic                 cand_ok;
  logic                 place_last;
  logic                 busy_d;
  logic                 done_d;
  logic [3:0]           nb_count;
  int                   nb_r;
  int                   nb_c;

`ifdef BOMB_PLACER_SAFE_START_EN
  logic [5:0]           safe_q;
`else
  logic                 unused_safe_cell;
  assign unused_safe_cell = ^safe_cell;
`endif

  // Candidate selection: LFSR draw, or linear probe once retries are exhausted
  always_comb begin
    probe_mode = (retry == RETRY_W'(RETRY_LIMIT));
    cand       = probe_mode ? probe_ptr : lfsr[5:0];
`ifdef BOMB_PLACER_SAFE_START_EN
    cand_ok    = !bomb_map[cand] && (cand != safe_q);
`else
    cand_ok    = !bomb_map[cand];
`endif
    place_last = cand_ok && ((placed + 6'd1) == target);
  end

  // Bombs among the in-bounds neighbours of cell ptr; no wrap at the board edges
  always_comb begin
    nb_count = 4'd0;
    nb_r     = 0;
    nb_c     = 0;
    for (int dr = -1; dr <= 1; dr++) begin
      for (int dc = -1; dc <= 1; dc++) begin
        nb_r = int'(ptr[5:3]) + dr;
        nb_c = int'(ptr[2:0]) + dc;
        if (!(dr == 0 && dc == 0) && nb_r >= 0 && nb_r < 8 && nb_c >= 0 && nb_c < 8)
          nb_count = nb_count + 4'(bomb_map[6'(nb_r * 8 + nb_c)]);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (bomb_count == 6'd0) ? COUNT : PLACE;
      PLACE:   if (place_last) state_next = COUNT;
      COUNT:   if (ptr == 6'd63) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Decoded from the next state so the registered outputs line up with the state
  always_comb begin
    busy_d = 1'b0;
    done_d = 1'b0;
    if (state_next == PLACE || state_next == COUNT) busy_d = 1'b1;
    if (state_next == DONE) done_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr      <= LFSR_SEED;
      bomb_map  <= 64'd0;
      adj_count <= 256'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
      target    <= 6'd0;
      placed    <= 6'd0;
      retry     <= '0;
      probe_ptr <= 6'd0;
      ptr       <= 6'd0;
`ifdef BOMB_PLACER_SAFE_START_EN
      safe_q    <= 6'd0;
`endif
    end else begin
      lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      busy <= busy_d;
      done <= done_d;
      case (state)
        IDLE: begin
          if (start) begin
            bomb_map  <= 64'd0;
            adj_count <= 256'd0;
            target    <= bomb_count;
            placed    <= 6'd0;
            retry     <= '0;
            ptr       <= 6'd0;
`ifdef BOMB_PLACER_SAFE_START_EN
            // bomb_count is 6 bits, so the target never exceeds the 63 allowed cells
            safe_q    <= safe_cell;
`endif
          end
        end
        PLACE: begin
          if (cand_ok) begin
            bomb_map[cand] <= 1'b1;
            placed         <= placed + 6'd1;
            retry          <= '0;
          end else begin
            retry     <= probe_mode ? retry : retry + RETRY_W'(1);
            probe_ptr <= probe_mode ? probe_ptr + 6'd1 : cand;
          end
          if (place_last) ptr <= 6'd0;
        end
        COUNT: begin
          adj_count[{ptr, 2'b00} +: 4] <= nb_count;
          ptr                          <= ptr + 6'd1;
        end
        default: ;
      endcase
    end
  end

endmodule
